// File: rtl/reg_file_pkg.sv
// Shared types and sizes for the register file and its scoreboard.
// Optional feature: REG_FILE_BYPASS_EN enables writeback-to-read bypass.
package reg_file_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;
    localparam int XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t addr_rs1;
        reg_idx_t addr_rs2;
    } reg_file_read_params_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: busy bits set on allocation, cleared on writeback,
// and the read stall derived from them. REG_FILE_BYPASS_EN lets a same-cycle writeback clear a hazard.
module reg_file_scoreboard
    import reg_file_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req_i,
    input  reg_idx_t             addr_rs1_i,
    input  reg_idx_t             addr_rs2_i,
    input  logic                 alloc_valid_i,
    input  reg_idx_t             alloc_rd_i,
    input  logic                 wb_valid_i,
    input  reg_idx_t             wb_rd_i,
    output logic                 rd_stall_o,
    output logic [REG_COUNT-1:0] busy_o
);

    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic                 hz1, hz2;

    // Allocation is applied after the clear so a same-cycle alloc+wb leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i)
            busy_d[wb_rd_i] = 1'b0;
        if (alloc_valid_i && alloc_rd_i != '0)
            busy_d[alloc_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    always_comb begin
        hz1 = (addr_rs1_i != '0) && busy_q[addr_rs1_i];
        hz2 = (addr_rs2_i != '0) && busy_q[addr_rs2_i];
`ifdef REG_FILE_BYPASS_EN
        if (wb_valid_i && wb_rd_i == addr_rs1_i)
            hz1 = 1'b0;
        if (wb_valid_i && wb_rd_i == addr_rs2_i)
            hz2 = 1'b0;
`endif
    end

    assign rd_stall_o = rd_req_i && (hz1 || hz2);
    assign busy_o     = busy_q;

endmodule

// File: rtl/reg_file.sv
// 32x32 register file with two registered read ports gated by a pending-write scoreboard.
// Optional feature: REG_FILE_BYPASS_EN forwards same-cycle writeback data into a granted read.
module reg_file
    import reg_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  reg_file_read_params_t rd_params,
    input  logic                  rd_req,
    output logic                  rd_stall,
    output logic                  rd_ack,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    input  logic                  alloc_valid,
    input  logic [REG_ADDR_W-1:0] alloc_rd,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic [REG_COUNT-1:0]  busy
);

    logic [XLEN-1:0] regs_q [REG_COUNT];
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [XLEN-1:0] rs1_src, rs2_src;
    logic            rd_ack_q, rd_ack_d;
    logic            grant;

    reg_file_scoreboard u_sb (
        .clk          (clk),
        .rst          (rst),
        .rd_req_i     (rd_req),
        .addr_rs1_i   (rd_params.addr_rs1),
        .addr_rs2_i   (rd_params.addr_rs2),
        .alloc_valid_i(alloc_valid),
        .alloc_rd_i   (alloc_rd),
        .wb_valid_i   (wb_valid),
        .wb_rd_i      (wb_rd),
        .rd_stall_o   (rd_stall),
        .busy_o       (busy)
    );

    assign grant = rd_req && !rd_stall;

    always_comb begin
        rs1_src = (rd_params.addr_rs1 == '0) ? '0 : regs_q[rd_params.addr_rs1];
        rs2_src = (rd_params.addr_rs2 == '0) ? '0 : regs_q[rd_params.addr_rs2];
`ifdef REG_FILE_BYPASS_EN
        if (wb_valid && wb_rd != '0 && wb_rd == rd_params.addr_rs1)
            rs1_src = wb_data;
        if (wb_valid && wb_rd != '0 && wb_rd == rd_params.addr_rs2)
            rs2_src = wb_data;
`endif
    end

    // Operand registers hold their last granted value across stalls and idle cycles.
    always_comb begin
        rd_ack_d = grant;
        rs1_d    = grant ? rs1_src : rs1_q;
        rs2_d    = grant ? rs2_src : rs2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ack_q <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
        end else begin
            rd_ack_q <= rd_ack_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs_q[i] <= '0;
        end else if (wb_valid && wb_rd != '0) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    assign rd_ack   = rd_ack_q;
    assign rs1_data = rs1_q;
    assign rs2_data = rs2_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed + random bench for reg_file with a queue scoreboard of expected operands.
// Build with REG_FILE_BYPASS_EN defined to check the bypass variant.
module tb_reg_file;
    import reg_file_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    reg_file_read_params_t rd_params;
    logic                  rd_req;
    logic                  rd_stall;
    logic                  rd_ack;
    logic [31:0]           rs1_data, rs2_data;
    logic                  alloc_valid;
    logic [4:0]            alloc_rd;
    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic [31:0]           wb_data;
    logic [31:0]           busy;

    reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .rd_params  (rd_params),
        .rd_req     (rd_req),
        .rd_stall   (rd_stall),
        .rd_ack     (rd_ack),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .alloc_valid(alloc_valid),
        .alloc_rd   (alloc_rd),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic [63:0] exp_q [$];
    logic [31:0] last_rs1, last_rs2;
    logic        obs_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
        if (wb_valid && wb_rd == a) return wb_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic m_hz(input logic [4:0] a);
        logic h;
        h = (a != 5'd0) && m_busy[a];
`ifdef REG_FILE_BYPASS_EN
        if (wb_valid && wb_rd == a) h = 1'b0;
`endif
        return h;
    endfunction

    task automatic drive(input logic req, input logic [4:0] r1, input logic [4:0] r2,
                         input logic av, input logic [4:0] ard,
                         input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
        rd_req = req; rd_params.addr_rs1 = r1; rd_params.addr_rs2 = r2;
        alloc_valid = av; alloc_rd = ard;
        wb_valid = wv; wb_rd = wrd; wb_data = wd;
    endtask

    // One clock: check stall, push expected read, advance model, then check outputs.
    task automatic cycle();
        logic        exp_stall, grant;
        logic [63:0] e;
        #1;
        exp_stall = rd_req && (m_hz(rd_params.addr_rs1) || m_hz(rd_params.addr_rs2));
        obs_stall = rd_stall;
        chk("rd_stall", {31'd0, rd_stall}, {31'd0, exp_stall});
        grant = rd_req && !exp_stall;
        if (grant) exp_q.push_back({m_read(rd_params.addr_rs1), m_read(rd_params.addr_rs2)});
        if (wb_valid && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        if (wb_valid) m_busy[wb_rd] = 1'b0;
        if (alloc_valid && alloc_rd != 5'd0) m_busy[alloc_rd] = 1'b1;
        m_busy[0] = 1'b0;
        @(posedge clk); #1;
        chk("rd_ack", {31'd0, rd_ack}, {31'd0, grant});
        if (grant) begin
            e = exp_q.pop_front();
            chk("rs1_data", rs1_data, e[63:32]);
            chk("rs2_data", rs2_data, e[31:0]);
            last_rs1 = e[63:32];
            last_rs2 = e[31:0];
        end else begin
            chk("rs1_hold", rs1_data, last_rs1);
            chk("rs2_hold", rs2_data, last_rs2);
        end
        chk("busy", busy, m_busy);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_busy   = 32'd0;
        last_rs1 = 32'd0;
        last_rs2 = 32'd0;
        exp_q.delete();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 32'd0);
        @(negedge clk); @(negedge clk);
        chk("reset_ack", {31'd0, rd_ack}, 32'd0);
        chk("reset_busy", busy, 32'd0);
        chk("reset_rs1", rs1_data, 32'd0);
        chk("reset_rs2", rs2_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read after reset
        drive(1, 5, 6, 0, 0, 0, 0, 32'd0); cycle();
        chk("rst_read_rs1", rs1_data, 32'd0);

        // Write then read
        drive(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF); cycle();
        drive(1, 5, 0, 0, 0, 0, 0, 32'd0); cycle();
        chk("wr_rd_rs1", rs1_data, 32'hDEADBEEF);
        chk("wr_rd_rs2", rs2_data, 32'd0);

        // x0 ignores alloc and writes
        drive(0, 0, 0, 1, 0, 1, 0, 32'h1234); cycle();
        chk("x0_busy", {31'd0, busy[0]}, 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0, 32'd0); cycle();
        chk("x0_read", rs1_data, 32'd0);

        // Hazard on x7
        drive(0, 0, 0, 1, 7, 0, 0, 32'd0); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 7, 0, 0, 0, 0, 0, 32'd0); cycle();
            chk("hz_stall", {31'd0, obs_stall}, 32'd1);
            chk("hz_noack", {31'd0, rd_ack}, 32'd0);
        end
        drive(1, 7, 0, 0, 0, 1, 7, 32'h55); cycle();
`ifdef REG_FILE_BYPASS_EN
        chk("hz_byp_grant", {31'd0, obs_stall}, 32'd0);
        chk("hz_byp_ack", {31'd0, rd_ack}, 32'd1);
`else
        chk("hz_wb_stall", {31'd0, obs_stall}, 32'd1);
        drive(1, 7, 0, 0, 0, 0, 0, 32'd0); cycle();
        chk("hz_grant", {31'd0, obs_stall}, 32'd0);
`endif
        chk("hz_data", rs1_data, 32'h55);

        // Simultaneous alloc + wb on x9
        drive(0, 0, 0, 1, 9, 1, 9, 32'hA5A5_0009); cycle();
        chk("sim_busy9", {31'd0, busy[9]}, 32'd1);
        drive(1, 0, 9, 0, 0, 0, 0, 32'd0); cycle();
        chk("sim_stall", {31'd0, obs_stall}, 32'd1);
        drive(0, 0, 0, 0, 0, 1, 9, 32'hA5A5_0009); cycle();
        drive(1, 0, 9, 0, 0, 0, 0, 32'd0); cycle();
        chk("sim_data", rs2_data, 32'hA5A5_0009);

        // Random traffic over a small address range to provoke hazards
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 1, 3, 32'h77); cycle();

        // Reset asserted in a grant cycle
        drive(1, 3, 3, 0, 0, 0, 0, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", {31'd0, rd_ack}, 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_rs1", rs1_data, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 32'd0);
        rst = 1'b0;
        model_reset();
        cycle();
        drive(1, 3, 5, 0, 0, 0, 0, 32'd0); cycle();
        chk("post_rst_rs1", rs1_data, 32'd0);
        chk("post_rst_rs2", rs2_data, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 32'd0); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
